md_io_ctrl: RTL and testbench
=============================

Name: md_io_ctrl

Overview:
CPU-facing controller for the MegaDrive I/O ports at $A10001-$A1001F (odd bytes). It owns the version, DATA, CTRL and serial registers for the three ports: port 1, port 2 and EXT. It drives the direction and output values into the pad datapath, assembles reads from pin state, and raises the TH (HL) interrupt request toward the VDP. It sits between the 68k bus decoder and md_io, feeding port1_in/port1_dir/port2_in/port2_dir and consuming port1_out/port2_out.

Parameters:
EXT_PINS, 7'h7F, pin value returned for the EXT port (no device attached).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
EXPORT  in  1  version bit 7 (1 = overseas)
PAL  in  1  version bit 6
sel  in  1  access request; held until ack
addr  in  4  register index = CPU A[4:1]
we  in  1  1 = write, 0 = read
din  in  8  write data
dout  out  8  read data, valid while ack = 1
ack  out  1  one-cycle access acknowledge
port1_out  in  7  pin levels from pad datapath, port 1
port2_out  in  7  pin levels from pad datapath, port 2
port1_in  out  7  CPU-driven pin values, port 1
port1_dir  out  7  pin direction, port 1 (1 = output from console)
port2_in  out  7  CPU-driven pin values, port 2
port2_dir  out  7  pin direction, port 2
hl_irq  out  1  level interrupt request to VDP

Behaviour:
Clocking and reset
- One clock domain (clk). Reset is synchronous and active-high.
- Reset values: DATA1/2/3 = 8'h7F; CTRL1/2/3 = 8'h00; TxD1/2/3 = 8'hFF; SCTRL1/2/3 = 8'h00; irq pending = 0.
- Outputs after reset: ack = 0, dout = 0, hl_irq = 0, port*_dir = 0, port*_in = 7'h7F.

Register map (addr)
- 0: version, read-only = {EXPORT, PAL, 1'b1, 1'b0, 4'h0}.
- 1-3: DATA1-3.
- 4-6: CTRL1-3.
- 7/8/9: TxD1, RxD1, SCTRL1.
- A/B/C: same three for port 2.
- D/E/F: same three for EXT.
- RxD always reads 8'h00. Writes to RxD and to version are ignored.
- SCTRL: only bits 7:3 are writable; bits 2:0 read 0.
- Serial transfer is not implemented; TxD and SCTRL are storage only.

Bus handshake
- An access starts on the first cycle with sel = 1 and no access in flight.
- ack pulses exactly one cycle later, with dout valid in that cycle.
- Writes commit on the cycle ack is asserted.
- No new access starts until sel has been low for at least one cycle, so a held sel yields a single ack.
- On reset mid-access, the pending ack is dropped.

Read assembly
- DATAn read = {DATAn[7], (DATAn[6:0] & CTRLn[6:0]) | (pins_n & ~CTRLn[6:0])}.
- pins_n is sampled in the request cycle; EXT pins = EXT_PINS.
- CTRL read returns the stored value.

Drive
- portN_in = DATAN[6:0] and portN_dir = CTRLN[6:0], registered.
- Both update the cycle after the write commits.

TH interrupt, per port
- th_prev is registered from the TH pin (pin bit 6).
- The port's pending flag sets on th_prev = 1 and current TH = 0, but only while CTRLn[7] = 1 and CTRLn[6] = 0.
- Pending clears on a read of DATAn, or on a CTRLn write with bit 7 = 0.
- If set and clear occur in the same cycle, set wins.
- hl_irq = OR of the pending flags, registered: it asserts one cycle after the flag sets.
- Enabling CTRLn[7] while TH is already low does not set pending.

Decomposition:
- Package md_io_pkg holds:
  - register index constants (REG_VER, REG_DATA1 … REG_SCTRL3);
  - reset constants (DATA_RST = 8'h7F, CTRL_RST = 8'h00, TXD_RST = 8'hFF);
  - SCTRL_WMASK = 8'hF8.
- One sub-module, io_port_regs, instantiated three times. It holds DATA/CTRL/TxD/SCTRL, read assembly, TH edge detect and the pending flag for one port.
- The top level holds address decode, the ack/handshake FSM (IDLE, ACK, WAIT_RELEASE), the version register and the hl_irq OR.

Test Plan:
- Reset, then read addr 0 with EXPORT=1, PAL=0 -> ack one cycle after sel, dout = 8'hA0. Also read DATA1 -> 8'h7F, CTRL1 -> 8'h00, TxD1 -> 8'hFF.
- Write CTRL1 = 8'h40, then DATA1 = 8'h00, with port1_out = 7'h3F -> port1_dir = 7'h40, port1_in = 7'h00; read DATA1 = 8'h3F. Then write DATA1 = 8'h40 -> read 8'h7F.
- Write CTRL2 = 8'h80, then drive port2_out[6] 1→0 -> hl_irq = 1 two cycles after the edge. Read DATA2 -> hl_irq = 0 the cycle after ack. A second falling edge coinciding with that read cycle -> hl_irq stays 1.
- Hold sel = 1 for 6 cycles with we = 1 on TxD3, din = 8'h55 -> exactly one ack, TxD3 = 8'h55. Write SCTRL1 = 8'hFF -> reads 8'hF8. Write RxD1 = 8'h12 -> reads 8'h00.
- Assert reset in the cycle after sel during a write to CTRL1 = 8'h7F -> ack never asserts, CTRL1 = 8'h00, port1_dir = 0, hl_irq = 0.
- With CTRL1 = 8'h80 and TH held low, write CTRL1 = 8'hC0, then CTRL1 = 8'h80 -> no interrupt. TH rising then falling -> hl_irq = 1. Write CTRL1 = 8'h00 -> hl_irq = 0.

Source files
------------

// File: rtl/md_io_pkg.sv
// Shared constants for the MegaDrive I/O port controller: register indices,
// reset values and the handshake state encoding.
package md_io_pkg;

    localparam logic [3:0] REG_VER    = 4'h0;
    localparam logic [3:0] REG_DATA1  = 4'h1;
    localparam logic [3:0] REG_DATA2  = 4'h2;
    localparam logic [3:0] REG_DATA3  = 4'h3;
    localparam logic [3:0] REG_CTRL1  = 4'h4;
    localparam logic [3:0] REG_CTRL2  = 4'h5;
    localparam logic [3:0] REG_CTRL3  = 4'h6;
    localparam logic [3:0] REG_TXD1   = 4'h7;
    localparam logic [3:0] REG_RXD1   = 4'h8;
    localparam logic [3:0] REG_SCTRL1 = 4'h9;
    localparam logic [3:0] REG_TXD2   = 4'hA;
    localparam logic [3:0] REG_RXD2   = 4'hB;
    localparam logic [3:0] REG_SCTRL2 = 4'hC;
    localparam logic [3:0] REG_TXD3   = 4'hD;
    localparam logic [3:0] REG_RXD3   = 4'hE;
    localparam logic [3:0] REG_SCTRL3 = 4'hF;

    localparam logic [7:0] DATA_RST    = 8'h7F;
    localparam logic [7:0] CTRL_RST    = 8'h00;
    localparam logic [7:0] TXD_RST     = 8'hFF;
    localparam logic [7:0] SCTRL_RST   = 8'h00;
    localparam logic [7:0] SCTRL_WMASK = 8'hF8;

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StWaitRelease
    } ack_state_e;

endpackage

// File: rtl/io_port_regs.sv
// Register set for one controller port: DATA/CTRL/TxD/SCTRL storage, DATA read
// assembly, pin drive registers and the TH falling-edge interrupt flag.
module io_port_regs
    import md_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] pins,
    input  logic       wr_data,
    input  logic       wr_ctrl,
    input  logic       wr_txd,
    input  logic       wr_sctrl,
    input  logic       rd_data,
    input  logic [7:0] wdata,
    output logic [7:0] data_rd,
    output logic [7:0] ctrl_rd,
    output logic [7:0] txd_rd,
    output logic [7:0] sctrl_rd,
    output logic [6:0] pin_val,
    output logic [6:0] pin_dir,
    output logic       pending
);

    logic [7:0] data_q, data_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] txd_q, txd_d;
    logic [7:0] sctrl_q, sctrl_d;
    logic [6:0] pin_val_q, pin_val_d;
    logic [6:0] pin_dir_q, pin_dir_d;
    logic       th_prev_q, th_prev_d;
    logic       pending_q, pending_d;
    logic       th_set, th_clr;

    always_comb begin
        data_d    = wr_data  ? wdata : data_q;
        ctrl_d    = wr_ctrl  ? wdata : ctrl_q;
        txd_d     = wr_txd   ? wdata : txd_q;
        sctrl_d   = wr_sctrl ? (wdata & SCTRL_WMASK) : sctrl_q;
        pin_val_d = data_q[6:0];
        pin_dir_d = ctrl_q[6:0];
        th_prev_d = pins[6];

        // Falling TH only counts while TH is an input with interrupts enabled.
        th_set    = th_prev_q && !pins[6] && ctrl_q[7] && !ctrl_q[6];
        th_clr    = rd_data || (wr_ctrl && !wdata[7]);
        pending_d = th_set ? 1'b1 : (th_clr ? 1'b0 : pending_q);

        data_rd  = {data_q[7], (data_q[6:0] & ctrl_q[6:0]) | (pins & ~ctrl_q[6:0])};
        ctrl_rd  = ctrl_q;
        txd_rd   = txd_q;
        sctrl_rd = sctrl_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= DATA_RST;
            ctrl_q    <= CTRL_RST;
            txd_q     <= TXD_RST;
            sctrl_q   <= SCTRL_RST;
            pin_val_q <= DATA_RST[6:0];
            pin_dir_q <= CTRL_RST[6:0];
            th_prev_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            txd_q     <= txd_d;
            sctrl_q   <= sctrl_d;
            pin_val_q <= pin_val_d;
            pin_dir_q <= pin_dir_d;
            th_prev_q <= th_prev_d;
            pending_q <= pending_d;
        end
    end

    assign pin_val = pin_val_q;
    assign pin_dir = pin_dir_q;
    assign pending = pending_q;

endmodule

// File: rtl/md_io_ctrl.sv
// CPU-facing MegaDrive I/O register block: bus handshake, address decode,
// version register, three port register sets and the TH interrupt request.
module md_io_ctrl
    import md_io_pkg::*;
#(
    parameter logic [6:0] EXT_PINS = 7'h7F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EXPORT,
    input  logic       PAL,
    input  logic       sel,
    input  logic [3:0] addr,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       ack,
    input  logic [6:0] port1_out,
    input  logic [6:0] port2_out,
    output logic [6:0] port1_in,
    output logic [6:0] port1_dir,
    output logic [6:0] port2_in,
    output logic [6:0] port2_dir,
    output logic       hl_irq
);

    ack_state_e state_q, state_d;
    logic [7:0] dout_q, dout_d;
    logic       hl_irq_q, hl_irq_d;
    logic       req;
    logic [7:0] rd_mux;

    logic [6:0] pins     [3];
    logic [7:0] data_rd  [3];
    logic [7:0] ctrl_rd  [3];
    logic [7:0] txd_rd   [3];
    logic [7:0] sctrl_rd [3];
    logic [6:0] pin_val  [3];
    logic [6:0] pin_dir  [3];
    logic [2:0] pending;

    assign pins[0] = port1_out;
    assign pins[1] = port2_out;
    assign pins[2] = EXT_PINS;

    // Reads sample and writes commit in the request cycle; ack follows it.
    assign req = sel && (state_q == StIdle);

    for (genvar p = 0; p < 3; p++) begin : g_port
        localparam logic [3:0] IdxData  = 4'(REG_DATA1 + p);
        localparam logic [3:0] IdxCtrl  = 4'(REG_CTRL1 + p);
        localparam logic [3:0] IdxTxd   = 4'(REG_TXD1 + 3 * p);
        localparam logic [3:0] IdxSctrl = 4'(REG_SCTRL1 + 3 * p);

        io_port_regs u_regs (
            .clk      (clk),
            .reset    (reset),
            .pins     (pins[p]),
            .wr_data  (req && we && (addr == IdxData)),
            .wr_ctrl  (req && we && (addr == IdxCtrl)),
            .wr_txd   (req && we && (addr == IdxTxd)),
            .wr_sctrl (req && we && (addr == IdxSctrl)),
            .rd_data  (req && !we && (addr == IdxData)),
            .wdata    (din),
            .data_rd  (data_rd[p]),
            .ctrl_rd  (ctrl_rd[p]),
            .txd_rd   (txd_rd[p]),
            .sctrl_rd (sctrl_rd[p]),
            .pin_val  (pin_val[p]),
            .pin_dir  (pin_dir[p]),
            .pending  (pending[p])
        );
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            REG_VER:    rd_mux = {EXPORT, PAL, 1'b1, 1'b0, 4'h0};
            REG_DATA1:  rd_mux = data_rd[0];
            REG_DATA2:  rd_mux = data_rd[1];
            REG_DATA3:  rd_mux = data_rd[2];
            REG_CTRL1:  rd_mux = ctrl_rd[0];
            REG_CTRL2:  rd_mux = ctrl_rd[1];
            REG_CTRL3:  rd_mux = ctrl_rd[2];
            REG_TXD1:   rd_mux = txd_rd[0];
            REG_SCTRL1: rd_mux = sctrl_rd[0];
            REG_TXD2:   rd_mux = txd_rd[1];
            REG_SCTRL2: rd_mux = sctrl_rd[1];
            REG_TXD3:   rd_mux = txd_rd[2];
            REG_SCTRL3: rd_mux = sctrl_rd[2];
            default:    rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dout_d   = req ? rd_mux : 8'h00;
        hl_irq_d = |pending;
        unique case (state_q)
            StIdle:        if (sel) state_d = StAck;
            StAck:         state_d = sel ? StWaitRelease : StIdle;
            StWaitRelease: if (!sel) state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            dout_q   <= 8'h00;
            hl_irq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            hl_irq_q <= hl_irq_d;
        end
    end

    assign ack       = (state_q == StAck);
    assign dout      = dout_q;
    assign hl_irq    = hl_irq_q;
    assign port1_in  = pin_val[0];
    assign port1_dir = pin_dir[0];
    assign port2_in  = pin_val[1];
    assign port2_dir = pin_dir[1];

endmodule

// File: tb/tb_md_io_ctrl.sv
// Bench for md_io_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a register-map level reference model.
module tb_md_io_ctrl;

    localparam logic [6:0] EXT_PINS = 7'h7F;

    logic       clk = 1'b0;
    logic       reset, EXPORT, PAL, sel, we, ack, hl_irq;
    logic [3:0] addr;
    logic [7:0] din, dout;
    logic [6:0] port1_out, port2_out, port1_in, port1_dir, port2_in, port2_dir;

    always #5 clk = ~clk;

    md_io_ctrl #(.EXT_PINS(EXT_PINS)) dut (
        .clk       (clk),
        .reset     (reset),
        .EXPORT    (EXPORT),
        .PAL       (PAL),
        .sel       (sel),
        .addr      (addr),
        .we        (we),
        .din       (din),
        .dout      (dout),
        .ack       (ack),
        .port1_out (port1_out),
        .port2_out (port2_out),
        .port1_in  (port1_in),
        .port1_dir (port1_dir),
        .port2_in  (port2_in),
        .port2_dir (port2_dir),
        .hl_irq    (hl_irq)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_data [3];
    logic [7:0] m_ctrl [3];
    logic [7:0] m_txd  [3];
    logic [7:0] m_sctrl[3];
    logic       m_pend [3];
    logic       m_thp  [3];
    logic [6:0] m_in   [3];
    logic [6:0] m_dir  [3];
    logic       m_ack, m_irq, m_armed;
    logic [7:0] m_dout;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] pins_of(input int p);
        if (p == 0) return port1_out;
        if (p == 1) return port2_out;
        return EXT_PINS;
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] a);
        int ai = int'(a);
        logic [7:0] r;
        logic [6:0] pv;
        if (ai == 0) return {EXPORT, PAL, 2'b10, 4'h0};
        if (ai <= 3) begin
            pv = pins_of(ai - 1);
            r[7] = m_data[ai - 1][7];
            // Output pins read back the latched value, input pins read the pad.
            for (int b = 0; b < 7; b++)
                r[b] = m_ctrl[ai - 1][b] ? m_data[ai - 1][b] : pv[b];
            return r;
        end
        if (ai <= 6) return m_ctrl[ai - 4];
        if ((ai - 7) % 3 == 0) return m_txd[(ai - 7) / 3];
        if ((ai - 7) % 3 == 2) return m_sctrl[(ai - 7) / 3];
        return 8'h00;
    endfunction

    task automatic model_step();
        int  ai = int'(addr);
        logic start;
        logic any_pend;
        if (reset) begin
            for (int p = 0; p < 3; p++) begin
                m_data[p] = 8'h7F; m_ctrl[p] = 8'h00; m_txd[p] = 8'hFF; m_sctrl[p] = 8'h00;
                m_pend[p] = 1'b0;  m_thp[p] = 1'b0;   m_in[p] = 7'h7F;  m_dir[p] = 7'h00;
            end
            m_ack = 1'b0; m_irq = 1'b0; m_dout = 8'h00; m_armed = 1'b1;
            return;
        end
        start    = sel && m_armed;
        any_pend = m_pend[0] || m_pend[1] || m_pend[2];
        m_dout   = start ? model_read(addr) : 8'h00;
        for (int p = 0; p < 3; p++) begin
            logic [6:0] pv = pins_of(p);
            logic set_i = m_thp[p] && !pv[6] && m_ctrl[p][7] && !m_ctrl[p][6];
            logic clr_i = start && (ai == p + 1) && (!we || (we && 1'b0));
            if (start && we && ai == p + 4 && !din[7]) clr_i = 1'b1;
            m_in[p]  = m_data[p][6:0];
            m_dir[p] = m_ctrl[p][6:0];
            m_pend[p] = set_i || (m_pend[p] && !clr_i);
            m_thp[p]  = pv[6];
        end
        if (start && we) begin
            if (ai >= 1 && ai <= 3) m_data[ai - 1] = din;
            else if (ai >= 4 && ai <= 6) m_ctrl[ai - 4] = din;
            else if (ai >= 7 && (ai - 7) % 3 == 0) m_txd[(ai - 7) / 3] = din;
            else if (ai >= 7 && (ai - 7) % 3 == 2) m_sctrl[(ai - 7) / 3] = din & 8'hF8;
        end
        m_ack   = start;
        m_irq   = any_pend;
        m_armed = start ? 1'b0 : (sel ? m_armed : 1'b1);
    endtask

    task automatic compare_all();
        check("ack", 8'(ack), 8'(m_ack));
        check("dout", dout, m_dout);
        check("hl_irq", 8'(hl_irq), 8'(m_irq));
        check("port1_in", 8'(port1_in), 8'(m_in[0]));
        check("port1_dir", 8'(port1_dir), 8'(m_dir[0]));
        check("port2_in", 8'(port2_in), 8'(m_in[1]));
        check("port2_dir", 8'(port2_dir), 8'(m_dir[1]));
    endtask

    // One clock: drive at negedge, advance model, sample at the next negedge.
    task automatic cyc(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
        sel = s; we = w; addr = a; din = d;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic access(input logic w, input logic [3:0] a, input logic [7:0] d);
        cyc(1'b1, w, a, d);
        cyc(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic read_expect(input string tag, input logic [3:0] a, input logic [7:0] exp);
        check({tag, "_pre_ack"}, 8'(ack), 8'h00);
        cyc(1'b1, 1'b0, a, 8'h00);
        check({tag, "_ack"}, 8'(ack), 8'h01);
        check(tag, dout, exp);
        cyc(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    initial begin
        int acks;
        reset = 1'b1; EXPORT = 1'b1; PAL = 1'b0; sel = 1'b0; we = 1'b0;
        addr = 4'h0; din = 8'h00; port1_out = 7'h7F; port2_out = 7'h7F;
        @(negedge clk);
        idle(2);
        check("rst_ack", 8'(ack), 8'h00);
        check("rst_irq", 8'(hl_irq), 8'h00);
        check("rst_p1dir", 8'(port1_dir), 8'h00);
        check("rst_p1in", 8'(port1_in), 8'h7F);
        reset = 1'b0;
        idle(1);

        read_expect("version", 4'h0, 8'hA0);
        read_expect("data1_rst", 4'h1, 8'h7F);
        read_expect("ctrl1_rst", 4'h4, 8'h00);
        read_expect("txd1_rst", 4'h7, 8'hFF);

        access(1'b1, 4'h4, 8'h40);
        access(1'b1, 4'h1, 8'h00);
        port1_out = 7'h3F;
        idle(1);
        check("p1dir_40", 8'(port1_dir), 8'h40);
        check("p1in_00", 8'(port1_in), 8'h00);
        read_expect("data1_mix", 4'h1, 8'h3F);
        access(1'b1, 4'h1, 8'h40);
        read_expect("data1_th_out", 4'h1, 8'h7F);

        access(1'b1, 4'h5, 8'h80);
        idle(1);
        port2_out = 7'h3F;
        idle(1);
        check("irq_one_after_edge", 8'(hl_irq), 8'h00);
        idle(1);
        check("irq_two_after_edge", 8'(hl_irq), 8'h01);
        port2_out = 7'h7F;
        idle(1);
        port2_out = 7'h3F;
        cyc(1'b1, 1'b0, 4'h2, 8'h00);
        check("irq_set_wins_ack", 8'(hl_irq), 8'h01);
        cyc(1'b0, 1'b0, 4'h0, 8'h00);
        check("irq_set_wins_after", 8'(hl_irq), 8'h01);
        read_expect("data2_clear", 4'h2, 8'h3F);
        check("irq_cleared_by_read", 8'(hl_irq), 8'h00);

        acks = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, 4'hD, 8'h55);
            acks += int'(ack);
        end
        idle(1);
        check("held_sel_acks", 8'(acks), 8'h01);
        read_expect("txd3", 4'hD, 8'h55);
        access(1'b1, 4'h9, 8'hFF);
        read_expect("sctrl1_mask", 4'h9, 8'hF8);
        access(1'b1, 4'h8, 8'h12);
        read_expect("rxd1_zero", 4'h8, 8'h00);

        reset = 1'b1;
        acks = 0;
        cyc(1'b1, 1'b1, 4'h4, 8'h7F);
        acks += int'(ack);
        cyc(1'b1, 1'b1, 4'h4, 8'h7F);
        acks += int'(ack);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 4'h0, 8'h00);
        acks += int'(ack);
        check("reset_drops_ack", 8'(acks), 8'h00);
        read_expect("ctrl1_after_reset", 4'h4, 8'h00);
        check("p1dir_after_reset", 8'(port1_dir), 8'h00);
        check("irq_after_reset", 8'(hl_irq), 8'h00);

        port1_out = 7'h3F;
        access(1'b1, 4'h4, 8'h80);
        idle(2);
        access(1'b1, 4'h4, 8'hC0);
        access(1'b1, 4'h4, 8'h80);
        idle(2);
        check("no_irq_th_low", 8'(hl_irq), 8'h00);
        port1_out = 7'h7F;
        idle(1);
        port1_out = 7'h3F;
        idle(2);
        check("irq_port1", 8'(hl_irq), 8'h01);
        access(1'b1, 4'h4, 8'h00);
        check("irq_ctrl_clear", 8'(hl_irq), 8'h00);

        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 63) == 0);
            EXPORT = 1'($urandom);
            PAL    = 1'($urandom);
            if ($urandom_range(0, 3) == 0) port1_out = 7'($urandom);
            if ($urandom_range(0, 3) == 0) port2_out = 7'($urandom);
            cyc(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
        end
        reset = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
